// File: rtl/mux_int_arb.sv
// Round-robin arbiter in front of the two-input mux_int datapath: grants one
// requester at a time, bounds hold time under contention, registers the result.
module mux_int_arb #(
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_req1,
  input  logic              in_req2,
  input  logic [0:DATA_W-1] in_data1,
  input  logic [0:DATA_W-1] in_data2,
  output logic              out_sel1,
  output logic              out_sel2,
  output logic [0:DATA_W-1] out_data,
  output logic              out_valid,
  output logic              out_src
);

  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    hold_q, hold_d;
  logic                ptr_q, ptr_d;
  logic                sel1_q, sel2_q;
  logic [0:DATA_W-1]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                src_q, src_d;
  logic                other_req_s;
  logic                xfer1_s, xfer2_s;

  // State, arbitration bookkeeping and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      ptr_q   <= 1'b0;
      sel1_q  <= 1'b0;
      sel2_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
      sel1_q  <= (state_d == GNT1);
      sel2_q  <= (state_d == GNT2);
      data_q  <= data_d;
      valid_q <= valid_d;
      src_q   <= src_d;
    end
  end

  // Next-state: round-robin from IDLE, direct hand-over, forced rotation at hold limit
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_req1 && in_req2)  state_d = ptr_q ? GNT2 : GNT1;
        else if (in_req1)        state_d = GNT1;
        else if (in_req2)        state_d = GNT2;
        else                     state_d = IDLE;
      end
      GNT1: begin
        if (!in_req1)                               state_d = in_req2 ? GNT2 : IDLE;
        else if (in_req2 && (hold_q == HOLD_LAST))  state_d = GNT2;
        else                                        state_d = GNT1;
      end
      GNT2: begin
        if (!in_req2)                               state_d = in_req1 ? GNT1 : IDLE;
        else if (in_req1 && (hold_q == HOLD_LAST))  state_d = GNT1;
        else                                        state_d = GNT2;
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold counter only advances while the holder keeps the mux against a waiting peer
  always_comb begin
    case (state_q)
      GNT1:    other_req_s = in_req2;
      GNT2:    other_req_s = in_req1;
      default: other_req_s = 1'b0;
    endcase

    if (state_d != state_q)        hold_d = '0;
    else if (other_req_s)          hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + CNT_W'(1);
    else                           hold_d = '0;

    if ((state_d != state_q) && (state_d == GNT1))       ptr_d = 1'b1;
    else if ((state_d != state_q) && (state_d == GNT2))  ptr_d = 1'b0;
    else                                                 ptr_d = ptr_q;
  end

  // Transfer capture: request is sampled together with the registered select
  always_comb begin
    xfer1_s = sel1_q & in_req1;
    xfer2_s = sel2_q & in_req2;
    if (xfer1_s) begin
      data_d  = in_data1;
      src_d   = 1'b0;
      valid_d = 1'b1;
    end else if (xfer2_s) begin
      data_d  = in_data2;
      src_d   = 1'b1;
      valid_d = 1'b1;
    end else begin
      data_d  = data_q;
      src_d   = src_q;
      valid_d = 1'b0;
    end
  end

  assign out_sel1  = sel1_q;
  assign out_sel2  = sel2_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_src   = src_q;

endmodule

// File: tb/tb_mux_int_arb.sv
// Directed bench for mux_int_arb with a grant/transfer model checked every cycle.
module tb_mux_int_arb;

  localparam int DW = 32;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_req1 = 1'b0;
  logic          in_req2 = 1'b0;
  logic [DW-1:0] in_data1 = '0;
  logic [DW-1:0] in_data2 = '0;
  logic          out_sel1, out_sel2, out_valid, out_src;
  logic [DW-1:0] out_data;

  int checks = 0;
  int failures = 0;

  // Model: who holds the mux, how long it has held it against a waiting peer,
  // who was served last, and the registered transfer outputs.
  int            m_gnt;
  int            m_run;
  int            m_last;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_src;

  mux_int_arb #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_req1  (in_req1),
    .in_req2  (in_req2),
    .in_data1 (in_data1),
    .in_data2 (in_data2),
    .out_sel1 (out_sel1),
    .out_sel2 (out_sel2),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_src  (out_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_gnt   = 0;
    m_run   = 0;
    m_last  = 2;
    m_data  = '0;
    m_valid = 1'b0;
    m_src   = 1'b0;
  endtask

  task automatic model_step(input logic r1, input logic r2,
                            input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    int   ng;
    int   other;
    logic mine;
    logic peer;
    if (m_gnt == 1 && r1) begin
      m_data = d1; m_src = 1'b0; m_valid = 1'b1;
    end else if (m_gnt == 2 && r2) begin
      m_data = d2; m_src = 1'b1; m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (m_gnt == 0) begin
      peer = 1'b0;
      if (r1 && r2)  ng = (m_last == 1) ? 2 : 1;
      else if (r1)   ng = 1;
      else if (r2)   ng = 2;
      else           ng = 0;
    end else begin
      mine  = (m_gnt == 1) ? r1 : r2;
      peer  = (m_gnt == 1) ? r2 : r1;
      other = 3 - m_gnt;
      if (!mine)                        ng = peer ? other : 0;
      else if (peer && m_run >= MH - 1) ng = other;
      else                              ng = m_gnt;
    end
    if (ng != m_gnt)  m_run = 0;
    else if (peer)    m_run = (m_run + 1 > MH - 1) ? MH - 1 : m_run + 1;
    else              m_run = 0;
    if (ng != m_gnt && ng != 0) m_last = ng;
    m_gnt = ng;
  endtask

  // One clock: drive inputs, advance model, compare after the edge.
  task automatic step(input logic r1, input logic r2,
                      input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    logic obs_x;
    in_req1  = r1;
    in_req2  = r2;
    in_data1 = d1;
    in_data2 = d2;
    obs_x = (out_sel1 & r1) | (out_sel2 & r2);
    model_step(r1, r2, d1, d2);
    @(posedge clk);
    #1;
    chk("model", {out_sel1, out_sel2, out_valid, out_src, out_data},
                 {(m_gnt == 1), (m_gnt == 2), m_valid, m_src, m_data});
    chk("onehot", 64'(out_sel1 & out_sel2), 64'd0);
    chk("valid_cause", 64'(out_valid & ~obs_x), 64'd0);
  endtask

  task automatic check_zero(input string name);
    chk(name, {out_sel1, out_sel2, out_valid, out_src, out_data}, 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_req1 = 1'b0; in_req2 = 1'b0;
    in_data1 = '0;  in_data2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    do_reset();

    // Both requesting from IDLE after reset: runs of 4
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b1, 32'd1024, 32'd5678);
      if (i == 1) chk("rr_first_sel1", 64'(out_sel1), 64'd1);
      if (i == 4) chk("rr_sel1_run_end", 64'(out_sel1), 64'd1);
      if (i == 5) begin
        chk("rr_rotate_sel2", 64'(out_sel2), 64'd1);
        chk("rr_data1_last", 64'(out_data), 64'd1024);
      end
      if (i == 6) chk("rr_data2_src", {out_src, out_data}, {1'b1, 32'd5678});
      if (i == 9) chk("rr_back_sel1", 64'(out_sel1), 64'd1);
    end
    repeat (3) step(1'b0, 1'b0, 32'd0, 32'd0);

    // Single requester latency
    do_reset();
    step(1'b1, 1'b0, 32'd4096, 32'd0);
    chk("lat_sel", {out_sel1, out_sel2, out_valid}, {1'b1, 1'b0, 1'b0});
    step(1'b1, 1'b0, 32'd4096, 32'd0);
    chk("lat_data", {out_sel2, out_valid, out_src, out_data}, {1'b0, 1'b1, 1'b0, 32'd4096});
    repeat (2) step(1'b0, 1'b0, 32'd0, 32'd0);

    // Requester 1 served last: tie goes to requester 2
    step(1'b1, 1'b1, 32'd11, 32'd22);
    chk("tie_after_r1", {out_sel1, out_sel2}, {1'b0, 1'b1});
    step(1'b1, 1'b1, 32'd11, 32'd22);
    repeat (2) step(1'b0, 1'b0, 32'd0, 32'd0);

    // Direct hand-over on request drop
    step(1'b1, 1'b0, 32'd7, 32'd1234);
    step(1'b1, 1'b1, 32'd7, 32'd1234);
    step(1'b0, 1'b1, 32'd7, 32'd1234);
    chk("drop_handover", {out_sel1, out_sel2, out_valid}, {1'b0, 1'b1, 1'b0});
    step(1'b0, 1'b1, 32'd7, 32'd1234);
    chk("drop_data", {out_valid, out_src, out_data}, {1'b1, 1'b1, 32'd1234});
    repeat (2) step(1'b0, 1'b0, 32'd0, 32'd0);

    // Requester 2 served last: tie goes to requester 1
    step(1'b1, 1'b1, 32'd33, 32'd44);
    chk("tie_after_r2", {out_sel1, out_sel2}, {1'b1, 1'b0});

    // Intermittent peer request clears the hold count
    for (int i = 0; i < 12; i++)
      step(1'b1, (i % 3) != 2, 32'(100 + i), 32'(200 + i));
    repeat (2) step(1'b0, 1'b0, 32'd0, 32'd0);

    // Asynchronous reset mid-GNT2
    step(1'b0, 1'b1, 32'd0, 32'd99);
    step(1'b0, 1'b1, 32'd0, 32'd99);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    in_req1 = 1'b1; in_req2 = 1'b1;
    @(posedge clk);
    #1;
    check_zero("held_reset");
    rst_n = 1'b1;
    step(1'b1, 1'b1, 32'd55, 32'd66);
    chk("post_reset_sel1", {out_sel1, out_sel2}, {1'b1, 1'b0});
    repeat (3) step(1'b1, 1'b1, 32'd55, 32'd66);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
